// File: rtl/io_port_peripheral.sv
// I/O port peripheral: input FIFO, output FIFO and interrupt FSM for the core.
// Ports:
//   clk, rst (async active-low)
//   ext_in_data/ext_in_valid/ext_in_ready : external agent -> input FIFO
//   in_port/in_empty/in_read              : input FIFO head -> core IN port
//   out_port/out_write                    : core OUT port -> output FIFO
//   ext_out_data/ext_out_valid/ext_out_ready : output FIFO -> external agent
//   irq_req/rti_done/interrupt            : interrupt request / return / line
//   err_underflow/err_overflow            : sticky error flags
module io_port_peripheral #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int INT_HOLD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] ext_in_data,
    input  logic              ext_in_valid,
    output logic              ext_in_ready,
    output logic [DATA_W-1:0] in_port,
    output logic              in_empty,
    input  logic              in_read,
    input  logic [DATA_W-1:0] out_port,
    input  logic              out_write,
    output logic [DATA_W-1:0] ext_out_data,
    output logic              ext_out_valid,
    input  logic              ext_out_ready,
    input  logic              irq_req,
    input  logic              rti_done,
    output logic              interrupt,
    output logic              err_underflow,
    output logic              err_overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int HW = (INT_HOLD > 1) ? $clog2(INT_HOLD) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(INT_HOLD - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ASSERT,
        S_SERVICE
    } state_e;

    // ---------------- input FIFO ----------------
    logic [DATA_W-1:0] in_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] in_mem_d [FIFO_DEPTH];
    logic [PW-1:0]     in_wr_q, in_wr_d;
    logic [PW-1:0]     in_rd_q, in_rd_d;
    logic [CW-1:0]     in_cnt_q, in_cnt_d;
    logic              err_underflow_q, err_underflow_d;
    logic              in_push, in_pop;

    assign ext_in_ready  = (in_cnt_q != DEPTH_C);
    assign in_empty      = (in_cnt_q == '0);
    assign in_port       = in_empty ? '0 : in_mem_q[in_rd_q];
    assign in_push       = ext_in_valid & ext_in_ready;
    assign in_pop        = in_read & ~in_empty;
    assign err_underflow = err_underflow_q;

    always_comb begin
        in_mem_d = in_mem_q;
        in_wr_d  = in_wr_q;
        in_rd_d  = in_rd_q;
        in_cnt_d = in_cnt_q;
        if (in_push) begin
            in_mem_d[in_wr_q] = ext_in_data;
            in_wr_d = in_wr_q + 1'b1;
        end
        if (in_pop) begin
            in_rd_d = in_rd_q + 1'b1;
        end
        case ({in_push, in_pop})
            2'b10:   in_cnt_d = in_cnt_q + 1'b1;
            2'b01:   in_cnt_d = in_cnt_q - 1'b1;
            default: in_cnt_d = in_cnt_q;
        endcase
        err_underflow_d = err_underflow_q | (in_read & in_empty);
    end

    // ---------------- output FIFO ----------------
    logic [DATA_W-1:0] out_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] out_mem_d [FIFO_DEPTH];
    logic [PW-1:0]     out_wr_q, out_wr_d;
    logic [PW-1:0]     out_rd_q, out_rd_d;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic              err_overflow_q, err_overflow_d;
    logic              out_full, out_push, out_pop;

    assign out_full      = (out_cnt_q == DEPTH_C);
    assign ext_out_valid = (out_cnt_q != '0);
    assign ext_out_data  = ext_out_valid ? out_mem_q[out_rd_q] : '0;
    assign out_pop       = ext_out_valid & ext_out_ready;
    // A full FIFO still takes the write when the head leaves this cycle;
    // the write slot is the one being vacated.
    assign out_push      = out_write & (~out_full | out_pop);
    assign err_overflow  = err_overflow_q;

    always_comb begin
        out_mem_d = out_mem_q;
        out_wr_d  = out_wr_q;
        out_rd_d  = out_rd_q;
        out_cnt_d = out_cnt_q;
        if (out_push) begin
            out_mem_d[out_wr_q] = out_port;
            out_wr_d = out_wr_q + 1'b1;
        end
        if (out_pop) begin
            out_rd_d = out_rd_q + 1'b1;
        end
        case ({out_push, out_pop})
            2'b10:   out_cnt_d = out_cnt_q + 1'b1;
            2'b01:   out_cnt_d = out_cnt_q - 1'b1;
            default: out_cnt_d = out_cnt_q;
        endcase
        err_overflow_d = err_overflow_q
                       | (out_write & out_full & ~out_pop);
    end

    // ---------------- interrupt FSM ----------------
    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pending_q, pending_d;
    logic          irq_q;
    logic          interrupt_q, interrupt_d;
    logic          rise;

    assign rise      = irq_req & ~irq_q;
    assign interrupt = interrupt_q;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        pending_d = pending_q;
        unique case (state_q)
            S_IDLE: begin
                if (rise) begin
                    state_d = S_ASSERT;
                    hold_d  = HOLD_LOAD;
                end
            end
            S_ASSERT: begin
                if (rise) begin
                    pending_d = 1'b1;
                end
                if (hold_q == '0) begin
                    state_d = S_SERVICE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            S_SERVICE: begin
                if (rti_done && (pending_q || rise)) begin
                    // Serve the pending request first; a fresh rise
                    // arriving alongside it takes over the pending slot.
                    state_d   = S_ASSERT;
                    hold_d    = HOLD_LOAD;
                    pending_d = pending_q & rise;
                end else if (rti_done) begin
                    state_d = S_IDLE;
                end else if (rise) begin
                    pending_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        interrupt_d = (state_d == S_ASSERT);
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_mem_q        <= '{default: '0};
            in_wr_q         <= '0;
            in_rd_q         <= '0;
            in_cnt_q        <= '0;
            err_underflow_q <= 1'b0;
            out_mem_q       <= '{default: '0};
            out_wr_q        <= '0;
            out_rd_q        <= '0;
            out_cnt_q       <= '0;
            err_overflow_q  <= 1'b0;
            state_q         <= S_IDLE;
            hold_q          <= '0;
            pending_q       <= 1'b0;
            irq_q           <= 1'b0;
            interrupt_q     <= 1'b0;
        end else begin
            in_mem_q        <= in_mem_d;
            in_wr_q         <= in_wr_d;
            in_rd_q         <= in_rd_d;
            in_cnt_q        <= in_cnt_d;
            err_underflow_q <= err_underflow_d;
            out_mem_q       <= out_mem_d;
            out_wr_q        <= out_wr_d;
            out_rd_q        <= out_rd_d;
            out_cnt_q       <= out_cnt_d;
            err_overflow_q  <= err_overflow_d;
            state_q         <= state_d;
            hold_q          <= hold_d;
            pending_q       <= pending_d;
            irq_q           <= irq_req;
            interrupt_q     <= interrupt_d;
        end
    end

endmodule

// File: doc/io_port_peripheral.md
Name: io_port_peripheral

Overview:
- Sits outside the processor core and drives the core's I/O pins: the input port, the output port and the interrupt line.
- External agents push input words into an input FIFO; the core reads them through a 16-bit port.
- Words the core writes to its output port go into an output FIFO, which external agents drain.
- An interrupt FSM turns external requests into interrupt pulses of fixed width and waits for the core's RTI before it raises the next one.

Parameters:
- DATA_W, 16, port word width.
- FIFO_DEPTH, 4, entries per FIFO; must be a power of 2 and at least 2.
- INT_HOLD, 2, number of cycles the interrupt line stays high per request.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ext_in_data  input  DATA_W  word offered by the external agent.
- ext_in_valid  input  1  ext_in_data is valid.
- ext_in_ready  output  1  input FIFO can accept a word (not full).
- in_port  output  DATA_W  input FIFO head word, fed to the core's input port.
- in_empty  output  1  input FIFO is empty.
- in_read  input  1  core consumed in_port this cycle (IN instruction).
- out_port  input  DATA_W  core's output port value.
- out_write  input  1  core wrote out_port this cycle (OUT instruction).
- ext_out_data  output  DATA_W  output FIFO head word.
- ext_out_valid  output  1  output FIFO is not empty.
- ext_out_ready  input  1  external agent accepts ext_out_data.
- irq_req  input  1  external interrupt request, level input.
- rti_done  input  1  one-cycle pulse: the core has completed RTI.
- interrupt  output  1  interrupt line to the core.
- err_underflow  output  1  sticky flag: in_read arrived while the input FIFO was empty.
- err_overflow  output  1  sticky flag: out_write arrived while the output FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous): both FIFOs empty with pointers at 0.
  - ext_in_ready=1, in_empty=1, in_port=0.
  - ext_out_valid=0, ext_out_data=0.
  - interrupt=0, FSM in IDLE, pending=0.
  - Both error flags 0; the registered copy of irq_req is 0.
- Reset mid-operation discards all FIFO contents and any pending interrupt.
- Input FIFO:
  - A push happens when ext_in_valid & ext_in_ready.
  - in_port is the combinational head word and reads 0 when the FIFO is empty.
  - A word pushed at edge n is visible on in_port after edge n.
  - in_read with in_empty=0 pops at the edge.
  - in_read with in_empty=1 leaves the FIFO unchanged and sets err_underflow.
  - Simultaneous push and pop on a non-empty FIFO keeps the count unchanged.
  - A push while full is impossible because ext_in_ready=0.
  - Pointers are log2(FIFO_DEPTH) bits and wrap; the count is log2(FIFO_DEPTH)+1 bits.
- Output FIFO:
  - out_write with the FIFO not full pushes out_port.
  - out_write while full drops the word and sets err_overflow.
  - However, out_write while full together with a pop in the same cycle is accepted.
  - A pop happens when ext_out_valid & ext_out_ready.
  - ext_out_data stays stable while ext_out_valid=1 and ext_out_ready=0.
- Error flags clear only on reset.
- Interrupt FSM: irq_req is registered once for edge detection; rise = irq_req & ~irq_req_q.
  - IDLE: on rise, go to ASSERT, load the hold counter with INT_HOLD-1, set interrupt=1 at the same edge.
  - ASSERT: interrupt=1; the counter decrements; at 0, go to SERVICE and set interrupt=0.
  - SERVICE: interrupt=0; on rti_done, go to IDLE, or go directly to ASSERT if pending=1 (which clears pending).
  - A rise while in ASSERT or SERVICE sets pending; pending holds at most one request and extra rises are lost.
  - rti_done in IDLE or ASSERT is ignored.
  - Simultaneous rise and rti_done in SERVICE: go to ASSERT.
- The interrupt output is driven directly from a register (no combinational path).

Test Plan:
- Reset, then push 0x1111, 0x2222, 0x3333, 0x4444 with ext_in_valid held high -> ext_in_ready=0 after the 4th push; in_port=0x1111. Pulse in_read 4 times -> in_port shows 0x2222, 0x3333, 0x4444, then 0 with in_empty=1.
- in_read while empty -> FIFO unchanged and err_underflow=1; the flag stays 1 until rst=0.
- Hold ext_out_ready=0 and issue 5 out_write with 0xA0..0xA4 -> ext_out_valid=1, err_overflow=1 after the 5th write. Release ready -> drains 0xA0..0xA3 in order, then ext_out_valid=0.
- irq_req rises at cycle 10 -> interrupt=1 for exactly 2 cycles, then 0. Second irq_req rise during SERVICE, then rti_done -> interrupt high again for 2 cycles on the next edge, with no IDLE cycle in between.
- Assert rst=0 asynchronously mid-ASSERT with both FIFOs holding 2 words -> interrupt=0, in_empty=1, ext_out_valid=0 immediately, with no clock edge required.
- Simultaneous push and in_read with 2 words held in the input FIFO for 10 cycles -> count stays 2 and words stay in order across the pointer wrap.
